// File: rtl/halfband_filter_clkgen_pkg.sv
// Shared constants for the clock-enable generator and 11-tap halfband FIR.
// Coefficients are 1s17 and sum to 131072, so the DC gain is exactly 1.0.
package halfband_filter_clkgen_pkg;

  localparam int DATA_W = 18;
  localparam int TAPS   = 11;
  localparam int ACC_W  = 38;

  localparam logic signed [DATA_W-1:0] H0 = 18'sd1638;
  localparam logic signed [DATA_W-1:0] H2 = -18'sd9830;
  localparam logic signed [DATA_W-1:0] H4 = 18'sd40960;
  localparam logic signed [DATA_W-1:0] H5 = 18'sd65536;

  // The centre tap is a power of two and is applied as a shift.
  localparam int H5_SHIFT = 16;
  localparam int OUT_SHIFT = 17;

  localparam int signed SAT_MAX = 131071;
  localparam int signed SAT_MIN = -131072;

endpackage

// File: rtl/halfband_filter_clkgen_clk_en_gen.sv
// Free-running divider producing nested single-cycle enables at
// clk/2, clk/4, clk/8 and clk/2^CNT_W.
module clk_en_gen #(
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  output logic sys_clk_en,
  output logic sys_clk2_en,
  output logic sam_clk_en,
  output logic sym_clk_en
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + CNT_W'(1);
  end

  // Decoding all-ones of the low bits keeps every slower pulse aligned with the faster ones.
  assign sys_clk_en  = ~reset & cnt[0];
  assign sys_clk2_en = ~reset & (&cnt[1:0]);
  assign sam_clk_en  = ~reset & (&cnt[2:0]);
  assign sym_clk_en  = ~reset & (&cnt);

endmodule

// File: rtl/halfband_filter_clkgen.sv
// Clock-enable generator plus 11-tap symmetric halfband FIR running on sys_clk2_en.
// Folded pre-adds, full-precision accumulate, floor scaling and saturation to 1s17.
module halfband_filter_clkgen #(
  parameter int DATA_W = 18,
  parameter int CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y,
  output logic                     sys_clk_en,
  output logic                     sys_clk2_en,
  output logic                     sam_clk_en,
  output logic                     sym_clk_en
);

  import halfband_filter_clkgen_pkg::TAPS;
  import halfband_filter_clkgen_pkg::ACC_W;
  import halfband_filter_clkgen_pkg::H0;
  import halfband_filter_clkgen_pkg::H2;
  import halfband_filter_clkgen_pkg::H4;
  import halfband_filter_clkgen_pkg::H5_SHIFT;
  import halfband_filter_clkgen_pkg::OUT_SHIFT;
  import halfband_filter_clkgen_pkg::SAT_MAX;
  import halfband_filter_clkgen_pkg::SAT_MIN;

  localparam int PROD_W = 2*DATA_W + 1;

  clk_en_gen #(.CNT_W(CNT_W)) u_clk_en_gen (
    .clk         (clk),
    .reset       (reset),
    .sys_clk_en  (sys_clk_en),
    .sys_clk2_en (sys_clk2_en),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en)
  );

  logic signed [DATA_W-1:0] d [0:TAPS-1];
  logic signed [DATA_W:0]   pre0, pre2, pre4;
  logic signed [PROD_W-1:0] m0, m2, m4;
  logic signed [ACC_W-1:0]  acc, scaled;
  logic signed [DATA_W-1:0] y_next;

  // Odd taps other than the centre are zero, so only three products are needed.
  always_comb begin
    pre0 = (DATA_W+1)'(d[0]) + (DATA_W+1)'(d[10]);
    pre2 = (DATA_W+1)'(d[2]) + (DATA_W+1)'(d[8]);
    pre4 = (DATA_W+1)'(d[4]) + (DATA_W+1)'(d[6]);
    m0   = PROD_W'(pre0) * PROD_W'(H0);
    m2   = PROD_W'(pre2) * PROD_W'(H2);
    m4   = PROD_W'(pre4) * PROD_W'(H4);
    acc  = ACC_W'(m0) + ACC_W'(m2) + ACC_W'(m4) + (ACC_W'(d[5]) <<< H5_SHIFT);
    scaled = acc >>> OUT_SHIFT;
    if (scaled > ACC_W'(SAT_MAX))      y_next = DATA_W'(SAT_MAX);
    else if (scaled < ACC_W'(SAT_MIN)) y_next = DATA_W'(SAT_MIN);
    else                               y_next = DATA_W'(scaled);
  end

  // y is computed from the delay line as it stood before this enable's shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) d[k] <= '0;
      y <= '0;
    end else if (sys_clk2_en) begin
      d[0] <= x_in;
      for (int k = 1; k < TAPS; k++) d[k] <= d[k-1];
      y <= y_next;
    end
  end

endmodule

// File: tb/tb_halfband_filter_clkgen.sv
// Directed bench for halfband_filter_clkgen: enable timing, impulse, DC step,
// saturation, gating of off-enable inputs and mid-stream reset.
module tb_halfband_filter_clkgen;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [17:0] x_in = '0;
  logic signed [17:0] y;
  logic               sys_clk_en, sys_clk2_en, sam_clk_en, sym_clk_en;

  int n_vec = 0;
  int n_err = 0;

  halfband_filter_clkgen dut (
    .clk         (clk),
    .reset       (reset),
    .x_in        (x_in),
    .y           (y),
    .sys_clk_en  (sys_clk_en),
    .sys_clk2_en (sys_clk2_en),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en)
  );

  always #5 clk = ~clk;

  localparam int P = 131071;
  localparam int N = -131072;

  int imp_exp [12] = '{819, 0, -4915, 0, 20480, 32768, 20480, 0, -4915, 0, 819, 0};
  int dc_exp  [12] = '{819, 819, -4096, -4096, 16384, 49152, 69632, 69632, 64717, 64717, 65536, 65536};
  int sat_pos [11] = '{P, 0, N, 0, P, P, P, 0, N, 0, P};
  int sat_neg [11] = '{N, 0, P, 0, N, N, N, 0, P, 0, N};

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Checks enable pattern starting from cnt=0 at the current negedge.
  task automatic check_en_seq(input int n);
    for (int k = 1; k <= n; k++) begin
      #1;
      chk("sys_clk_en",  int'(sys_clk_en),  int'(k % 2 == 0));
      chk("sys_clk2_en", int'(sys_clk2_en), int'(k % 4 == 0));
      chk("sam_clk_en",  int'(sam_clk_en),  int'(k % 8 == 0));
      chk("sym_clk_en",  int'(sym_clk_en),  int'(k % 32 == 0));
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    x_in  = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives xv on the next enable cycle; optionally scribbles x_in and checks y holds in between.
  task automatic step(input int xv, input bit junk, input bit hold_chk, input int hold_exp);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (sys_clk2_en) begin
        x_in  = 18'(xv);
        found = 1'b1;
      end else begin
        if (hold_chk) chk("hold_y", int'(y), hold_exp);
        if (junk) x_in = (i % 2 == 0) ? 18'sh1FFFF : 18'sh20000;
      end
    end
    if (!found) chk("en_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
      if (junk) x_in = ~x_in;
    end
  endtask

  initial begin
    int prev;

    repeat (4) begin
      @(negedge clk);
      #1;
      chk("rst_sys_en",  int'(sys_clk_en),  0);
      chk("rst_sys2_en", int'(sys_clk2_en), 0);
      chk("rst_sam_en",  int'(sam_clk_en),  0);
      chk("rst_sym_en",  int'(sym_clk_en),  0);
    end
    chk("rst_y", int'(y), 0);
    @(negedge clk);
    reset = 1'b0;
    check_en_seq(64);

    apply_reset();
    step(65536, 0, 0, 0);
    chk("imp_first", int'(y), 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      chk("impulse", int'(y), imp_exp[i]);
    end

    apply_reset();
    step(65536, 0, 0, 0);
    chk("dc_first", int'(y), 0);
    for (int i = 0; i < 12; i++) begin
      step(65536, 0, 0, 0);
      chk("dc_step", int'(y), dc_exp[i]);
    end

    apply_reset();
    for (int i = 0; i < 11; i++) step(sat_pos[i], 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sat_pos", int'(y), P);

    apply_reset();
    for (int i = 0; i < 11; i++) step(sat_neg[i], 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sat_neg", int'(y), N);

    apply_reset();
    step(-65536, 1, 1, 0);
    chk("gate_first", int'(y), 0);
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, prev);
      chk("gate_impulse", int'(y), -imp_exp[i]);
      prev = -imp_exp[i];
    end

    apply_reset();
    step(65536, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("pre_rst_imp", int'(y), imp_exp[i]);
    end
    @(negedge clk);
    reset = 1'b1;
    x_in  = '0;
    @(posedge clk);
    #1;
    chk("mid_rst_y", int'(y), 0);
    @(negedge clk);
    reset = 1'b0;
    check_en_seq(8);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      chk("post_rst_y", int'(y), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
